// File: rtl/grid_board.sv
// grid_board: 10x18 playfield store with lock writes and one-row-per-clock line collapse.
// Optional feature: define GRID_SCORE_EN to build the saturating score accumulator.
`timescale 1ns/1ps
module grid_board (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic                   clear_all,
  input  logic                   lock_valid,
  output logic                   lock_ready,
  input  logic [15:0]            lock_x,
  input  logic [19:0]            lock_y,
  input  logic [2:0]             lock_color,
  output logic [17:0][9:0][2:0]  grid,
  output logic [17:0][9:0]       occ,
  output logic                   busy,
  output logic                   lines_valid,
  output logic [2:0]             lines_cleared,
  output logic                   top_out,
  output logic [15:0]            score
);

  // state | meaning
  // IDLE  | waiting for a lock request
  // SCAN  | testing row `row` for fullness, bottom to top
  // SHIFT | moving rows above `sh` down by one, one row per clock
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  localparam logic [2:0] EMPTY_COLOR = 3'b011;
  localparam logic [9:0][2:0] EMPTY_ROW = {10{EMPTY_COLOR}};

  state_t     state, state_nx;
  logic [4:0] row, sh;
  logic [2:0] count;
  logic       accept, row_full, collide;
  logic [3:0] cx [4];
  logic [4:0] cy [4];
  logic       cv [4];

  assign lock_ready  = (state == IDLE) && !clear_all;
  assign busy        = (state != IDLE);
  assign lines_valid = (state == DONE);
  assign accept      = lock_valid && lock_ready;
  assign row_full    = (occ[row] == 10'h3FF);

  // Collision looks only at pre-lock occupancy, so duplicate cells in one lock never collide.
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cx[i] = lock_x[4*i +: 4];
      cy[i] = lock_y[5*i +: 5];
      cv[i] = (cx[i] <= 4'd9) && (cy[i] <= 5'd17);
      if (cv[i] && occ[cy[i]][cx[i]]) collide = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = SCAN;
      SCAN:  if (row_full) state_nx = SHIFT;
             else if (row == 5'd0) state_nx = DONE;
      SHIFT: if (sh <= 5'd1) state_nx = SCAN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear_all) state_nx = IDLE;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      occ           <= '0;
      grid          <= {18{EMPTY_ROW}};
      row           <= 5'd0;
      sh            <= 5'd0;
      count         <= 3'd0;
      lines_cleared <= 3'd0;
      top_out       <= 1'b0;
    end else if (clear_all) begin
      occ           <= '0;
      grid          <= {18{EMPTY_ROW}};
      row           <= 5'd0;
      sh            <= 5'd0;
      count         <= 3'd0;
      lines_cleared <= 3'd0;
      top_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          for (int i = 0; i < 4; i++) begin
            if (cv[i]) begin
              occ[cy[i]][cx[i]]  <= 1'b1;
              grid[cy[i]][cx[i]] <= lock_color;
            end
          end
          if (collide) top_out <= 1'b1;
          row   <= 5'd17;
          count <= 3'd0;
        end
        SCAN: begin
          if (row_full) begin
            sh    <= row;
            count <= count + 3'd1;
          end else if (row != 5'd0) begin
            row <= row - 5'd1;
          end else begin
            lines_cleared <= count;
          end
        end
        SHIFT: begin
          if (sh == 5'd0) begin
            occ[0]  <= '0;
            grid[0] <= EMPTY_ROW;
          end else begin
            occ[sh]  <= occ[sh - 5'd1];
            grid[sh] <= grid[sh - 5'd1];
            sh       <= sh - 5'd1;
            if (sh == 5'd1) begin
              occ[0]  <= '0;
              grid[0] <= EMPTY_ROW;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GRID_SCORE_EN
  logic [15:0] pts;
  logic [16:0] sum;

  always_comb begin
    case (count)
      3'd1:    pts = 16'd40;
      3'd2:    pts = 16'd100;
      3'd3:    pts = 16'd300;
      3'd4:    pts = 16'd1200;
      default: pts = 16'd0;
    endcase
    sum = {1'b0, score} + {1'b0, pts};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)            score <= 16'h0000;
    else if (clear_all)      score <= 16'h0000;
    else if (state == DONE)  score <= sum[16] ? 16'hFFFF : sum[15:0];
  end
`else
  assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_grid_board.sv
// Self-checking bench for grid_board against a row-compaction reference model.
`timescale 1ns/1ps
module tb_grid_board;

  logic                  vga_clk, reset_n, clear_all, lock_valid, lock_ready;
  logic [15:0]           lock_x;
  logic [19:0]           lock_y;
  logic [2:0]            lock_color;
  logic [17:0][9:0][2:0] grid;
  logic [17:0][9:0]      occ;
  logic                  busy, lines_valid, top_out;
  logic [2:0]            lines_cleared;
  logic [15:0]           score;

  grid_board dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .clear_all(clear_all),
    .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_x(lock_x), .lock_y(lock_y), .lock_color(lock_color),
    .grid(grid), .occ(occ), .busy(busy), .lines_valid(lines_valid),
    .lines_cleared(lines_cleared), .top_out(top_out), .score(score)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  localparam logic [17:0][9:0][2:0] EMPTY_GRID = {180{3'b011}};

  int checks = 0;
  int errors = 0;

  logic [17:0][9:0]      m_occ;
  logic [17:0][9:0][2:0] m_grid;
  logic                  m_top;
  int                    m_score;
  int                    exp_lat, exp_lines;

  function automatic void model_clear();
    m_occ   = '0;
    m_grid  = EMPTY_GRID;
    m_top   = 1'b0;
    m_score = 0;
  endfunction

  // Writes the lock, then compacts surviving rows downward; a full row is
  // detected at the index where the compacted stack currently stands.
  function automatic void model_lock(input logic [15:0] x, input logic [19:0] y, input logic [2:0] c);
    logic [17:0][9:0]      n_occ;
    logic [17:0][9:0][2:0] n_grid;
    int xi, yi, dst;
    for (int i = 0; i < 4; i++) begin
      xi = int'(x[4*i +: 4]);
      yi = int'(y[5*i +: 5]);
      if (xi <= 9 && yi <= 17 && m_occ[yi][xi]) m_top = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      xi = int'(x[4*i +: 4]);
      yi = int'(y[5*i +: 5]);
      if (xi <= 9 && yi <= 17) begin
        m_occ[yi][xi]  = 1'b1;
        m_grid[yi][xi] = c;
      end
    end
    n_occ = '0;
    n_grid = EMPTY_GRID;
    exp_lat = 19;
    exp_lines = 0;
    dst = 17;
    for (int src = 17; src >= 0; src--) begin
      if (m_occ[src] == 10'h3FF) begin
        exp_lat += ((dst > 0) ? dst : 1) + 1;
        exp_lines++;
      end else begin
        n_occ[dst]  = m_occ[src];
        n_grid[dst] = m_grid[src];
        dst--;
      end
    end
    m_occ = n_occ;
    m_grid = n_grid;
`ifdef GRID_SCORE_EN
    case (exp_lines)
      1: m_score += 40;
      2: m_score += 100;
      3: m_score += 300;
      4: m_score += 1200;
      default: ;
    endcase
    if (m_score > 65535) m_score = 65535;
`endif
  endfunction

  // Drives one lock; lat is the cycle index of the lines_valid pulse, with the
  // cycle right after the accepting edge as 1 (-1 when it never arrives).
  task automatic do_lock(input logic [15:0] x, input logic [19:0] y, input logic [2:0] c, output int lat);
    lat = -1;
    for (int k = 0; k < 100 && !lock_ready; k++) @(negedge vga_clk);
    @(negedge vga_clk);
    lock_valid = 1'b1; lock_x = x; lock_y = y; lock_color = c;
    @(posedge vga_clk); #1;
    lock_valid = 1'b0;
    for (int n = 2; n <= 400; n++) begin
      @(posedge vga_clk); #1;
      if (lines_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic clear_board();
    @(negedge vga_clk); clear_all = 1'b1;
    @(negedge vga_clk); clear_all = 1'b0;
    model_clear();
  endtask

  task automatic preload_rows(input int lo, input int hi, input logic [2:0] c);
    int lat;
    for (int r = lo; r <= hi; r++) begin
      model_lock({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'(r)}}, c); do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'(r)}}, c, lat);
      model_lock({4'd7, 4'd6, 4'd5, 4'd4}, {4{5'(r)}}, c); do_lock({4'd7, 4'd6, 4'd5, 4'd4}, {4{5'(r)}}, c, lat);
      model_lock({4{4'd8}}, {4{5'(r)}}, c);                do_lock({4{4'd8}}, {4{5'(r)}}, c, lat);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (lock_ready !== 1'b1 || busy !== 1'b0 || lines_valid !== 1'b0 || lines_cleared !== 3'd0 ||
        top_out !== 1'b0 || score !== 16'h0) begin
      errors++;
      $display("FAIL reset_flags: got ready=%b busy=%b lv=%b lc=%0d top=%b score=%0d, want 1 0 0 0 0 0",
               lock_ready, busy, lines_valid, lines_cleared, top_out, score);
    end
    checks++;
    if (occ !== '0 || grid !== EMPTY_GRID) begin
      errors++;
      $display("FAIL reset_grid: occ/grid not empty after reset");
    end
  endtask

  task automatic test_single_lock();
    int lat;
    clear_board();
    model_lock({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'd17}}, 3'b001);
    do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'd17}}, 3'b001, lat);
    checks++;
    if (lat !== 19) begin errors++; $display("FAIL single_latency: got %0d want 19", lat); end
    checks++;
    if (lines_cleared !== 3'd0) begin errors++; $display("FAIL single_lines: got %0d want 0", lines_cleared); end
    checks++;
    if (occ[17] !== 10'h00F || grid[17][3:0] !== {4{3'b001}}) begin
      errors++; $display("FAIL single_cells: occ17=%h want 00f grid17=%h", occ[17], grid[17]);
    end
    @(posedge vga_clk); #1;
    checks++;
    if (lines_valid !== 1'b0 || lock_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pulse_end: lv=%b ready=%b busy=%b want 0 1 0", lines_valid, lock_ready, busy);
    end
  endtask

  task automatic test_two_lines();
    int lat;
    clear_board();
    preload_rows(16, 17, 3'b010);
    model_lock({4{4'd9}}, {5'd17, 5'd16, 5'd15, 5'd14}, 3'b101);
    do_lock({4{4'd9}}, {5'd17, 5'd16, 5'd15, 5'd14}, 3'b101, lat);
    checks++;
    if (lat !== exp_lat || exp_lat !== 55) begin errors++; $display("FAIL two_latency: got %0d want %0d", lat, exp_lat); end
    checks++;
    if (lines_cleared !== 3'd2) begin errors++; $display("FAIL two_lines: got %0d want 2", lines_cleared); end
    checks++;
    if (occ[17] !== 10'h200 || occ[16] !== 10'h200 || occ[15:0] !== '0) begin
      errors++; $display("FAIL two_occ: occ17=%h occ16=%h want 200 200 rest 0", occ[17], occ[16]);
    end
    checks++;
    if (grid !== m_grid) begin errors++; $display("FAIL two_grid: colour array differs from model"); end
`ifdef GRID_SCORE_EN
    checks++;
    if (score !== 16'd100) begin errors++; $display("FAIL two_score: got %0d want 100", score); end
`endif
  endtask

  task automatic test_tetris();
    int lat;
    clear_board();
    preload_rows(14, 17, 3'b110);
    model_lock({4{4'd9}}, {5'd17, 5'd16, 5'd15, 5'd14}, 3'b111);
    do_lock({4{4'd9}}, {5'd17, 5'd16, 5'd15, 5'd14}, 3'b111, lat);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL tetris_latency: got %0d want %0d", lat, exp_lat); end
    checks++;
    if (lines_cleared !== 3'd4) begin errors++; $display("FAIL tetris_lines: got %0d want 4", lines_cleared); end
    checks++;
    if (occ !== '0 || grid !== EMPTY_GRID) begin errors++; $display("FAIL tetris_empty: grid not empty"); end
`ifdef GRID_SCORE_EN
    checks++;
    if (score !== 16'd1200) begin errors++; $display("FAIL tetris_score: got %0d want 1200", score); end
`endif
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [17:0][9:0] want;
    clear_board();
    want = '0;
    want[5][4] = 1'b1;
    do_lock({4'd4, 4'd4, 4'd4, 4'd12}, {5'd5, 5'd5, 5'd20, 5'd3}, 3'b100, lat);
    checks++;
    if (occ !== want || grid[5][4] !== 3'b100) begin errors++; $display("FAIL range_cells: only (4,5) should be written"); end
    checks++;
    if (top_out !== 1'b0) begin errors++; $display("FAIL range_top: got %b want 0", top_out); end
  endtask

  task automatic test_collision();
    int lat;
    clear_board();
    do_lock({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'd10}}, 3'b001, lat);
    do_lock({4'd5, 4'd5, 4'd5, 4'd2}, {4{5'd10}}, 3'b010, lat);
    checks++;
    if (top_out !== 1'b1 || grid[10][2] !== 3'b010) begin
      errors++; $display("FAIL collide_set: top=%b colour=%0d want 1 2", top_out, grid[10][2]);
    end
    do_lock({4{4'd7}}, {4{5'd3}}, 3'b010, lat);
    checks++;
    if (top_out !== 1'b1) begin errors++; $display("FAIL collide_sticky: got %b want 1", top_out); end
    clear_board();
    #1;
    checks++;
    if (top_out !== 1'b0 || occ !== '0 || grid !== EMPTY_GRID || score !== 16'h0 || lines_cleared !== 3'd0) begin
      errors++; $display("FAIL collide_clear: top=%b score=%0d lc=%0d or grid not empty", top_out, score, lines_cleared);
    end
  endtask

  task automatic test_clear_during_shift();
    int seen;
    clear_board();
    preload_rows(14, 17, 3'b001);
    @(negedge vga_clk);
    lock_valid = 1'b1; lock_x = {4{4'd9}}; lock_y = {5'd17, 5'd16, 5'd15, 5'd14}; lock_color = 3'b010;
    @(posedge vga_clk); #1;
    lock_valid = 1'b0;
    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    clear_all = 1'b1; lock_valid = 1'b1; lock_x = {4'd3, 4'd2, 4'd1, 4'd0}; lock_y = {4{5'd0}};
    @(posedge vga_clk); #1;
    checks++;
    if (occ !== '0 || grid !== EMPTY_GRID || busy !== 1'b0) begin
      errors++; $display("FAIL shift_clear: busy=%b or grid not empty after clear_all", busy);
    end
    @(negedge vga_clk);
    clear_all = 1'b0; lock_valid = 1'b0;
    model_clear();
    seen = 0;
    for (int n = 0; n < 120; n++) begin
      @(posedge vga_clk); #1;
      if (lines_valid) seen++;
    end
    checks++;
    if (seen !== 0 || occ !== '0 || busy !== 1'b0 || lines_cleared !== 3'd0) begin
      errors++; $display("FAIL shift_abandon: pulses=%0d busy=%b lc=%0d want 0 0 0, occ empty", seen, busy, lines_cleared);
    end
  endtask

  task automatic test_random_locks();
    int lat;
    logic [15:0] x;
    logic [19:0] y;
    logic [2:0]  c;
    clear_board();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        x[4*i +: 4] = 4'($urandom_range(0, 11));
        y[5*i +: 5] = 5'($urandom_range(12, 19));
      end
      c = 3'($urandom);
      model_lock(x, y, c);
      do_lock(x, y, c, lat);
      checks++;
      if (lat !== exp_lat || lines_cleared !== 3'(exp_lines) || occ !== m_occ || grid !== m_grid ||
          top_out !== m_top || score !== 16'(m_score)) begin
        errors++;
        $display("FAIL random_lock_%0d: lat=%0d/%0d lines=%0d/%0d top=%b/%b score=%0d/%0d grid_ok=%b",
                 t, lat, exp_lat, lines_cleared, exp_lines, top_out, m_top, score, m_score,
                 (occ === m_occ) && (grid === m_grid));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; clear_all = 1'b0; lock_valid = 1'b0;
    lock_x = '0; lock_y = '0; lock_color = '0;
    model_clear();
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk); reset_n = 1'b1;
    test_reset();
    test_single_lock();
    test_two_lines();
    test_tetris();
    test_out_of_range();
    test_collision();
    test_clear_during_shift();
    test_random_locks();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
